// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: access size codes (same values as
// load_extend's extend_sel) and the load/store sequencer state encoding.
package riscv_pkg;

    localparam int unsigned LSU_LANES = 4;

    typedef enum logic [2:0] {
        SZ_BYTE  = 3'd0,
        SZ_HALF  = 3'd1,
        SZ_WORD  = 3'd2,
        SZ_UBYTE = 3'd3,
        SZ_UHALF = 3'd4
    } size_e;

    typedef enum logic [1:0] {
        LSU_IDLE     = 2'd0,
        LSU_REQ      = 2'd1,
        LSU_WAIT_RSP = 2'd2,
        LSU_DONE     = 2'd3
    } lsu_state_e;

    function automatic logic size_ok(input logic [2:0] size);
        return size <= 3'd4;
    endfunction

    function automatic logic access_misaligned(input logic [2:0] size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (size == SZ_HALF || size == SZ_UHALF) mis = off[0];
        else if (size == SZ_WORD)                mis = (off != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for a
// request, plus right-aligned, width-masked load data for a returned word.
module lsu_lane_align
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [2:0]           size,
    input  logic [1:0]           off,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [WORD_SIZE-1:0] rdata,
    output logic [3:0]           be,
    output logic [WORD_SIZE-1:0] wdata_rep,
    output logic [WORD_SIZE-1:0] rdata_align
);

    logic [WORD_SIZE-1:0] shifted;

    always_comb begin
        shifted     = rdata >> {off, 3'b000};
        be          = 4'b0000;
        wdata_rep   = wdata;
        rdata_align = '0;
        case (size)
            SZ_BYTE, SZ_UBYTE: begin
                be          = 4'b0001 << off;
                wdata_rep   = {4{wdata[7:0]}};
                rdata_align = {{(WORD_SIZE-8){1'b0}}, shifted[7:0]};
            end
            SZ_HALF, SZ_UHALF: begin
                be          = 4'b0011 << off;
                wdata_rep   = {2{wdata[15:0]}};
                rdata_align = {{(WORD_SIZE-16){1'b0}}, shifted[15:0]};
            end
            SZ_WORD: begin
                be          = 4'b1111;
                wdata_rep   = wdata;
                rdata_align = shifted;
            end
            default: begin
                be          = 4'b0000;
                wdata_rep   = wdata;
                rdata_align = '0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer: one access at a time onto the data bus.
// Build option LSU_MISALIGN_TRAP_EN turns misaligned accesses into faults.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]  req_wdata,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [WORD_SIZE-1:0]  rsp_data,
    output logic [2:0]            rsp_size,
    output logic                  misalign_fault,
    output logic                  dmem_valid,
    input  logic                  dmem_ready,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [WORD_SIZE-1:0]  dmem_wdata,
    input  logic                  dmem_rvalid,
    input  logic [WORD_SIZE-1:0]  dmem_rdata,
    output lsu_state_e            state_o
);

    // Bus handshake: a request transfers on the rising edge where dmem_valid
    // and dmem_ready are both high; until then every dmem_* output is held.
    // Load data is taken on the first dmem_rvalid seen in WAIT_RSP only.

    lsu_state_e            state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            off_q, off_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WORD_SIZE-1:0]  rsp_data_q, rsp_data_d;
    logic [2:0]            rsp_size_q, rsp_size_d;
    logic                  fault_q, fault_d;
    logic                  dmem_valid_q, dmem_valid_d;
    logic                  dmem_we_q, dmem_we_d;
    logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]            dmem_be_q, dmem_be_d;
    logic [WORD_SIZE-1:0]  dmem_wdata_q, dmem_wdata_d;

    logic [1:0]            req_off;
    logic                  req_fault;
    logic [2:0]            align_size;
    logic [1:0]            align_off;
    logic [3:0]            align_be;
    logic [WORD_SIZE-1:0]  align_wdata;
    logic [WORD_SIZE-1:0]  align_rdata;

    // Misaligned halves keep addr[1]; misaligned words fall back to lane 0.
    always_comb begin
        req_off = req_addr[1:0];
        if (req_size == SZ_HALF || req_size == SZ_UHALF) req_off = {req_addr[1], 1'b0};
        else if (req_size == SZ_WORD)                    req_off = 2'b00;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_fault = size_ok(req_size) && access_misaligned(req_size, req_addr[1:0]);
`else
    assign req_fault = 1'b0;
`endif

    assign align_size = (state_q == LSU_IDLE) ? req_size : rsp_size_q;
    assign align_off  = (state_q == LSU_IDLE) ? req_off  : off_q;

    lsu_lane_align #(
        .WORD_SIZE (WORD_SIZE)
    ) u_lane_align (
        .size        (align_size),
        .off         (align_off),
        .wdata       (req_wdata),
        .rdata       (dmem_rdata),
        .be          (align_be),
        .wdata_rep   (align_wdata),
        .rdata_align (align_rdata)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        off_d        = off_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_size_d   = rsp_size_q;
        fault_d      = fault_q;
        dmem_valid_d = dmem_valid_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    off_d      = req_off;
                    rsp_size_d = req_size;
                    rsp_data_d = '0;
                    if (!size_ok(req_size) || req_fault) begin
                        state_d     = LSU_DONE;
                        rsp_valid_d = 1'b1;
                        fault_d     = req_fault;
                    end else begin
                        state_d      = LSU_REQ;
                        dmem_valid_d = 1'b1;
                        dmem_we_d    = req_we;
                        dmem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        dmem_be_d    = align_be;
                        dmem_wdata_d = align_wdata;
                    end
                end
            end
            LSU_REQ: begin
                if (dmem_ready) begin
                    dmem_valid_d = 1'b0;
                    if (we_q) begin
                        state_d     = LSU_DONE;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = LSU_WAIT_RSP;
                    end
                end
            end
            LSU_WAIT_RSP: begin
                if (dmem_rvalid) begin
                    rsp_data_d  = align_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = LSU_DONE;
                end
            end
            LSU_DONE: begin
                rsp_valid_d = 1'b0;
                fault_d     = 1'b0;
                state_d     = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LSU_IDLE;
            we_q         <= 1'b0;
            off_q        <= 2'b00;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_size_q   <= 3'd0;
            fault_q      <= 1'b0;
            dmem_valid_q <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= 4'b0000;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            off_q        <= off_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_size_q   <= rsp_size_d;
            fault_q      <= fault_d;
            dmem_valid_q <= dmem_valid_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    // Low in DONE so the pipeline advances in the same cycle as rsp_valid.
    assign busy = ((state_q != LSU_IDLE) && (state_q != LSU_DONE)) ||
                  ((state_q == LSU_IDLE) && req_valid);

    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_size       = rsp_size_q;
    assign misalign_fault = fault_q;
    assign dmem_valid     = dmem_valid_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_be        = dmem_be_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized accesses against a byte-lane reference model of the
// load/store sequencer, with cycle-exact handshake and response timing.
module tb_load_store_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_size;
    logic        misalign_fault;
    logic        dmem_valid;
    logic        dmem_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    lsu_state_e  state_o;

    int n_asserts = 0;
    int n_fail    = 0;

    load_store_unit #(
        .WORD_SIZE  (32),
        .ADDR_WIDTH (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .busy           (busy),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_size       (rsp_size),
        .misalign_fault (misalign_fault),
        .dmem_valid     (dmem_valid),
        .dmem_ready     (dmem_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] s);
        case (s)
            3'd0, 3'd3: return 1;
            3'd1, 3'd4: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_fault"},     32'(misalign_fault), 32'd0);
        chk({tag, "_dvalid"},    32'(dmem_valid), 32'd0);
        chk({tag, "_dwe"},       32'(dmem_we), 32'd0);
        chk({tag, "_dbe"},       32'(dmem_be), 32'd0);
        chk({tag, "_rsp_data"},  rsp_data, 32'd0);
        chk({tag, "_rsp_size"},  32'(rsp_size), 32'd0);
        chk({tag, "_daddr"},     dmem_addr, 32'd0);
        chk({tag, "_dwdata"},    dmem_wdata, 32'd0);
        chk({tag, "_state"},     32'(state_o), 32'(LSU_IDLE));
    endtask

    // One access, walked cycle by cycle from the accept cycle (c = 0).
    task automatic access(input string tag, input logic we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] mword, input int ready_wait, input int rv_delay);
        int n, a, off, h, rsp_c;
        logic valid, mis, fault, bus, on_bus, in_wait;
        logic [3:0]  ebe;
        logic [31:0] ewd, erd;
        n     = nbytes(size);
        valid = (n != 0);
        a     = int'(addr[1:0]);
        mis   = (n == 2 && addr[0]) || (n == 4 && a != 0);
`ifdef LSU_MISALIGN_TRAP_EN
        fault = valid && mis;
        bus   = valid && !mis;
`else
        fault = 1'b0;
        bus   = valid;
`endif
        off = valid ? (a - (a % n)) : 0;
        ebe = 4'b0000;
        ewd = 32'd0;
        erd = 32'd0;
        if (valid) begin
            for (int i = 0; i < 4; i++) begin
                ebe[i]          = (i >= off) && (i < off + n);
                ewd[8*i +: 8]   = wdata[8*(i % n) +: 8];
            end
            if (bus && !we)
                for (int k = 0; k < n; k++) erd[8*k +: 8] = mword[8*(off + k) +: 8];
        end
        h     = 1 + ready_wait;
        rsp_c = !bus ? 1 : (we ? h + 1 : h + rv_delay + 1);

        for (int c = 0; c <= rsp_c + 1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_valid = 1'b1;
                req_we    = we;
                req_size  = size;
                req_addr  = addr;
                req_wdata = wdata;
            end else if (c <= rsp_c) begin
                req_we    = 1'($urandom_range(0, 1));
                req_size  = 3'($urandom_range(0, 7));
                req_addr  = $urandom;
                req_wdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            on_bus  = bus && (c >= 1) && (c <= h);
            in_wait = bus && !we && (c > h) && (c <= h + rv_delay);
            dmem_ready = on_bus ? (c == h) : 1'($urandom_range(0, 1));
            if (in_wait) begin
                dmem_rvalid = (c == h + rv_delay);
                dmem_rdata  = (c == h + rv_delay) ? mword : $urandom;
            end else begin
                dmem_rvalid = 1'($urandom_range(0, 1));
                dmem_rdata  = $urandom;
            end
            #1;
            chk({tag, "_busy"},      32'(busy), 32'(c < rsp_c));
            chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(c == rsp_c));
            chk({tag, "_dvalid"},    32'(dmem_valid), 32'(on_bus));
            if (on_bus) begin
                chk({tag, "_daddr"}, dmem_addr, {addr[31:2], 2'b00});
                chk({tag, "_dbe"},   32'(dmem_be), 32'(ebe));
                chk({tag, "_dwe"},   32'(dmem_we), 32'(we));
                if (we) chk({tag, "_dwdata"}, dmem_wdata, ewd);
            end
            if (c == rsp_c) begin
                chk({tag, "_fault"},    32'(misalign_fault), 32'(fault));
                chk({tag, "_rsp_size"}, 32'(rsp_size), 32'(size));
                if (!we || !bus) chk({tag, "_rsp_data"}, rsp_data, erd);
            end
            if (c == rsp_c + 1) chk({tag, "_idle"}, 32'(state_o), 32'(LSU_IDLE));
        end
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_size    = 3'd0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;

        // Reset state; busy follows req_valid while idle.
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset");
        chk("reset_busy_hi", 32'(busy), 32'd1);
        req_valid = 1'b0;
        #1;
        chk("reset_busy_lo", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        access("lb_1003",   1'b0, 3'd0, 32'h0000_1003, 32'h0,         32'h8022_3344, 0, 1);
        access("sh_2002",   1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 32'h0,         0, 1);
        access("lw_wait",   1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 3, 2);
        access("lh_1001",   1'b0, 3'd1, 32'h0000_1001, 32'h0,         32'h1122_3344, 0, 1);
        access("inv_sz6",   1'b0, 3'd6, 32'h0000_0100, 32'h0,         32'hFFFF_FFFF, 0, 1);
        access("sb_lane2",  1'b1, 3'd3, 32'h0000_0302, 32'h1234_56A5, 32'h0,         1, 1);
        access("lhu_hi",    1'b0, 3'd4, 32'h0000_0406, 32'h0,         32'hA1B2_C3D4, 0, 3);
        access("sw_mis",    1'b1, 3'd2, 32'h0000_0503, 32'h0BAD_F00D, 32'h0,         2, 1);

        // Reset while a load waits for its data; the late data must be dropped.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 3'd2;
        req_addr   = 32'h0000_0040;
        @(negedge clk);
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        chk("rstmid_in_wait", 32'(state_o), 32'(LSU_WAIT_RSP));
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        check_reset_values("rstmid_async");
        @(negedge clk);
        rst         = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("rstmid_rv_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_rvalid = 1'b0;
            #1;
            check_reset_values("rstmid_after");
            chk("rstmid_after_busy", 32'(busy), 32'd0);
        end

        // Randomized accesses, sizes include the invalid codes.
        for (int t = 0; t < 60; t++) begin
            access("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
